// File: rtl/sram_responder.sv
// Single-request responder driving one asynchronous SRAM bank with programmable
// strobe width; every pin-side signal comes straight from a flop.
module sram_responder #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_out,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_in,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [3:0]        ram_be_n
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_q, resp_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_oe_q, data_oe_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              cnt_done;

    // Byte-lane bits and address bits above the SRAM window are dropped silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};

    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:2];
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    if (!req_we)
                        state_d = RD;
                    else if (req_be != 4'h0)
                        state_d = WR_SETUP;
                    else
                        state_d = DONE;
                end
            end
            RD: begin
                if (cnt_done) begin
                    rdata_d = ram_data_in;
                    state_d = DONE;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (cnt_done) state_d = WR_HOLD;
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // The counter restarts on every state entry and only runs in timed states.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == RD || state_q == WR_PULSE)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        // Pin values are decoded from the upcoming state so they land in a flop.
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = 4'hF;
        data_oe_d = 1'b0;
        resp_d    = 1'b0;
        case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = ~be_d;
            end
            WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                data_oe_d = 1'b1;
                be_n_d    = ~be_d;
            end
            DONE:    resp_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            resp_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= 4'hF;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_q;
    assign resp_rdata   = rdata_q;
    assign ram_addr     = addr_q;
    assign ram_data_out = wdata_q;
    assign ram_data_oe  = data_oe_q;
    assign ram_ce_n     = ce_n_q;
    assign ram_oe_n     = oe_n_q;
    assign ram_we_n     = we_n_q;
    assign ram_be_n     = be_n_q;

endmodule
